ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Round-robin arbiter that shares the single RAM port between NREQ memory requesters, such as the coherence controller's data path, instruction fetch and a debug loader.
- Sits between the requesters and the RAM model. Uses the ramstate_t handshake (FREE, BUSY, ACCESS, ERROR).
- Supports locked multi-word bursts so that a two-word cache-block transfer is never split by another requester.

Parameters:
- NREQ, 2, number of requesters (2..4); index width IW = $clog2(NREQ), minimum 1.
- MAX_BURST, 2, maximum words served per grant while lock is held.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- req_ren  in  NREQ  per-requester read request
- req_wen  in  NREQ  per-requester write request
- req_lock  in  NREQ  keep grant after the current word completes (burst)
- req_addr  in  NREQ x 32  per-requester word address (word_t)
- req_store  in  NREQ x 32  per-requester write data
- req_wait  out  NREQ  1 = requester must hold its request; 0 = word done this cycle
- req_load  out  NREQ x 32  read data; valid when req_wait[i]=0 and req_err[i]=0
- req_err  out  NREQ  one-cycle pulse: RAM returned ERROR
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t from RAM
- gnt_valid  out  1  a grant is active (GRANT or GAP state)
- gnt_id  out  IW  current or last granted requester

Behaviour:
- Clocking and reset: one clock CLK. Reset nRST is synchronous and active-low; all state changes at posedge CLK.
- Reset values:
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first), gnt_id=0, burst count=0.
  - Outputs: req_wait='1, req_load='0, req_err='0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, gnt_valid=0.
  - Reset asserted mid-grant aborts the transfer at that edge with no err pulse.
- Default every cycle: req_wait='1, req_load='0, req_err='0, all ram outputs 0.
- State IDLE:
  - Requester i is "requesting" if req_ren[i]|req_wen[i].
  - Winner = first requesting index scanning ptr+1, ptr+2, ... modulo NREQ.
  - If any requester is requesting, latch gnt_id=winner and burst count=0, then go to GRANT. Otherwise stay in IDLE.
  - Latency: a request sampled at edge t gets RAM enables driven in the cycle after t. No RAM enables in IDLE.
- State GRANT (g=gnt_id):
  - ramaddr=req_addr[g] and ramstore=req_store[g], combinational from g's live inputs.
  - ramWEN=req_wen[g]; ramREN=req_ren[g]&~req_wen[g] (write wins if both are set).
  - req_load[g]=ramload; req_wait[g]=~(ramstate==ACCESS). All other requesters keep req_wait=1.
  - ramstate==ACCESS: burst count+1.
    - If req_lock[g] && count+1<MAX_BURST, go to GAP.
    - Otherwise ptr=g, go to IDLE.
  - ramstate==ERROR: req_err[g]=1, req_wait[g]=0, ptr=g, go to IDLE.
  - If ACCESS and ERROR are both absent and g has dropped both ren and wen (abort): ptr=g, go to IDLE, no err.
  - FREE or BUSY: stay in GRANT.
- State GAP:
  - One dead cycle so the requester can present the next word. RAM enables 0, req_wait all 1, grant retained. Go to GRANT.
  - If req_lock[g] is deasserted during GAP, still return to GRANT. The next word is served; the requester is responsible for dropping ren/wen to abort.
- Fairness:
  - ptr updates only when a grant ends. With all requesters asserting continuously, grants rotate 0,1,...,NREQ-1,0.
  - A locked requester holds the port for at most MAX_BURST words and must re-arbitrate after that.
- gnt_valid=1 in GRANT and GAP. gnt_id holds its last value in IDLE.

Test Plan:
- Single read: req_ren[0]=1, addr=0x40, RAM BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF.
  -> ramREN=1 from the cycle after the request, ramaddr=0x40. req_wait[0]=0 and req_load[0]=0xDEADBEEF only in the ACCESS cycle. Then IDLE with ptr=0.
- Contention: req_ren[0] and req_wen[1] asserted continuously, each access immediate ACCESS.
  -> Grants alternate 0,1,0,1. No requester ever sees two consecutive grants.
- Locked burst: req_wen[1]=1 with lock=1 at addr 0x80 then 0x84, store 0x11 then 0x22, while req_ren[0]=1.
  -> RAM writes 0x80=0x11, one GAP cycle, then 0x84=0x22. Requester 0 is granted only after both words.
- Burst cap: lock held continuously by requester 0, MAX_BURST=2, requester 1 requesting.
  -> After the 2nd ACCESS the arbiter goes to IDLE and grants requester 1.
- Error and abort:
  - ramstate=ERROR during grant to 1 -> req_err[1]=1 for exactly one cycle, req_wait[1]=0, then IDLE.
  - Requester drops ren during BUSY -> IDLE next cycle, no err, no ACCESS.
- Both ren and wen set, then reset: req_ren[0]=req_wen[0]=1 -> ramWEN=1, ramREN=0. Assert nRST=0 in GRANT -> at the next edge all outputs are at reset values and ptr=NREQ-1.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for the round-robin RAM arbiter
interface ram_arbiter_if #(
   parameter int NREQ = 2
) ();
   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   // requester side
   logic [NREQ-1:0]         req_ren;
   logic [NREQ-1:0]         req_wen;
   logic [NREQ-1:0]         req_lock;
   logic [NREQ-1:0][31:0]   req_addr;
   logic [NREQ-1:0][31:0]   req_store;
   logic [NREQ-1:0]         req_wait;
   logic [NREQ-1:0][31:0]   req_load;
   logic [NREQ-1:0]         req_err;

   // RAM side
   logic                    ramREN;
   logic                    ramWEN;
   logic [31:0]             ramaddr;
   logic [31:0]             ramstore;
   logic [31:0]             ramload;
   logic [1:0]              ramstate;

   // grant status
   logic                    gnt_valid;
   logic [IW-1:0]           gnt_id;

   // arbiter side
   modport master (
      input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
      output req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore,
             gnt_valid, gnt_id
   );

   // requesters plus RAM model side
   modport slave (
      output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
      input  req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore,
             gnt_valid, gnt_id
   );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port among NREQ requesters with locked bursts
module ram_arbiter #(
   parameter int NREQ      = 2,
   parameter int MAX_BURST = 2
) (
   input  logic           CLK,
   input  logic           nRST,
   ram_arbiter_if.master  bus
);
   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] gnt;
   logic [CW-1:0] cnt;

   logic [IW-1:0] winner;
   logic          any_req;
   logic          g_active;
   logic          burst_more;

   // round-robin search starting just after the last requester that finished a grant
   always_comb begin
      logic [IW-1:0] idx;
      idx     = '0;
      winner  = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (!any_req && (bus.req_ren[idx] || bus.req_wen[idx])) begin
            any_req = 1'b1;
            winner  = idx;
         end
      end
   end

   assign g_active   = bus.req_ren[gnt] | bus.req_wen[gnt];
   assign burst_more = bus.req_lock[gnt] && ((int'(cnt) + 1) < MAX_BURST);

   // grant state machine: pointer only moves when a grant ends, so rotation is fair
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         ptr   <= IW'(NREQ - 1);
         gnt   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt   <= winner;
                  cnt   <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (bus.ramstate == RAM_ERROR) begin
                  ptr   <= gnt;
                  state <= IDLE;
               end else if (bus.ramstate == RAM_ACCESS) begin
                  cnt <= cnt + 1'b1;
                  if (burst_more) begin
                     state <= GAP;
                  end else begin
                     ptr   <= gnt;
                     state <= IDLE;
                  end
               end else if (!g_active) begin
                  ptr   <= gnt;
                  state <= IDLE;
               end
            end
            GAP: begin
               state <= GRANT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM port and requester responses follow the granted requester's live inputs
   always_comb begin
      bus.req_wait  = '1;
      bus.req_load  = '0;
      bus.req_err   = '0;
      bus.ramREN    = 1'b0;
      bus.ramWEN    = 1'b0;
      bus.ramaddr   = '0;
      bus.ramstore  = '0;
      bus.gnt_valid = (state != IDLE);
      bus.gnt_id    = gnt;
      if (state == GRANT) begin
         bus.ramaddr       = bus.req_addr[gnt];
         bus.ramstore      = bus.req_store[gnt];
         bus.ramWEN        = bus.req_wen[gnt];
         bus.ramREN        = bus.req_ren[gnt] & ~bus.req_wen[gnt];
         bus.req_load[gnt] = bus.ramload;
         bus.req_wait[gnt] = ~((bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR));
         bus.req_err[gnt]  = (bus.ramstate == RAM_ERROR);
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
   localparam int NREQ      = 2;
   localparam int MAX_BURST = 2;
   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   logic CLK = 1'b0;
   logic nRST;
   logic chk_on = 1'b0;
   int   total = 0;
   int   bad   = 0;

   ram_arbiter_if #(.NREQ(NREQ)) bus ();

   ram_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.master)
   );

   always #5 CLK = ~CLK;

   // reference model state: owner -1 means nobody holds the port
   int m_owner;
   bit m_gap;
   int m_words;
   int m_last;
   int m_ptr;

   logic [63:0] wlog[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // reference model advances on each rising edge from the inputs held across it
   always @(posedge CLK) begin : model
      int w;
      int c;
      int g;
      if (!nRST) begin
         m_owner <= -1;
         m_gap   <= 1'b0;
         m_words <= 0;
         m_last  <= 0;
         m_ptr   <= NREQ - 1;
      end else if (m_owner < 0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (w < 0 && (bus.req_ren[c] || bus.req_wen[c])) w = c;
         end
         if (w >= 0) begin
            m_owner <= w;
            m_last  <= w;
            m_words <= 0;
            m_gap   <= 1'b0;
         end
      end else if (m_gap) begin
         m_gap <= 1'b0;
      end else begin
         g = m_owner;
         if (bus.ramstate == ERROR) begin
            m_ptr   <= g;
            m_owner <= -1;
         end else if (bus.ramstate == ACCESS) begin
            m_words <= m_words + 1;
            if (bus.req_lock[g] && (m_words + 1) < MAX_BURST) begin
               m_gap <= 1'b1;
            end else begin
               m_ptr   <= g;
               m_owner <= -1;
            end
         end else if (!(bus.req_ren[g] || bus.req_wen[g])) begin
            m_ptr   <= g;
            m_owner <= -1;
         end
      end
   end

   // compare every DUT output against the model on the falling edge
   always @(negedge CLK) begin : compare
      logic [NREQ-1:0]       e_wait;
      logic [NREQ-1:0][31:0] e_load;
      logic [NREQ-1:0]       e_err;
      logic                  e_ren, e_wen, e_gv;
      logic [31:0]           e_addr, e_store;
      int                    g;
      if (chk_on) begin
         e_wait  = '1;
         e_load  = '0;
         e_err   = '0;
         e_ren   = 1'b0;
         e_wen   = 1'b0;
         e_addr  = '0;
         e_store = '0;
         e_gv    = (m_owner >= 0);
         if (m_owner >= 0 && !m_gap) begin
            g         = m_owner;
            e_addr    = bus.req_addr[g];
            e_store   = bus.req_store[g];
            e_wen     = bus.req_wen[g];
            e_ren     = bus.req_ren[g] && !bus.req_wen[g];
            e_load[g] = bus.ramload;
            e_wait[g] = !(bus.ramstate == ACCESS || bus.ramstate == ERROR);
            e_err[g]  = (bus.ramstate == ERROR);
         end
         chk("m_req_wait",  64'(bus.req_wait),  64'(e_wait));
         chk("m_req_load",  64'(bus.req_load),  64'(e_load));
         chk("m_req_err",   64'(bus.req_err),   64'(e_err));
         chk("m_ramREN",    64'(bus.ramREN),    64'(e_ren));
         chk("m_ramWEN",    64'(bus.ramWEN),    64'(e_wen));
         chk("m_ramaddr",   64'(bus.ramaddr),   64'(e_addr));
         chk("m_ramstore",  64'(bus.ramstore),  64'(e_store));
         chk("m_gnt_valid", 64'(bus.gnt_valid), 64'(e_gv));
         chk("m_gnt_id",    64'(bus.gnt_id),    64'(m_last));
         if (bus.ramWEN && bus.ramstate == ACCESS) wlog.push_back({bus.ramaddr, bus.ramstore});
      end
   end

   // directed scenarios with hand-computed checkpoints
   initial begin : stim
      logic exp_seq [4];
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
      nRST          = 1'b0;
      bus.req_ren   = '0;
      bus.req_wen   = '0;
      bus.req_lock  = '0;
      bus.req_addr  = '0;
      bus.req_store = '0;
      bus.ramload   = '0;
      bus.ramstate  = FREE;

      // reset
      step();
      chk_on = 1'b1;
      step();
      chk("rst_gnt_valid", 64'(bus.gnt_valid), 64'd0);
      chk("rst_req_wait",  64'(bus.req_wait),  64'h3);
      chk("rst_ramREN",    64'(bus.ramREN),    64'd0);
      chk("rst_ramaddr",   64'(bus.ramaddr),   64'd0);
      nRST = 1'b1;

      // single read with two BUSY cycles
      bus.req_ren[0]  = 1'b1;
      bus.req_addr[0] = 32'h40;
      bus.ramstate    = BUSY;
      bus.ramload     = 32'hDEADBEEF;
      #1;
      chk("rd_idle_noren", 64'(bus.ramREN), 64'd0);
      step(); #1;
      chk("rd_ren",    64'(bus.ramREN),      64'd1);
      chk("rd_addr",   64'(bus.ramaddr),     64'h40);
      chk("rd_wait",   64'(bus.req_wait[0]), 64'd1);
      step();
      step();
      bus.ramstate = ACCESS;
      #1;
      chk("rd_done_wait", 64'(bus.req_wait[0]), 64'd0);
      chk("rd_load",      64'(bus.req_load[0]), 64'hDEADBEEF);
      step();
      bus.req_ren[0] = 1'b0;
      bus.ramstate   = FREE;
      #1;
      chk("rd_idle_gv",  64'(bus.gnt_valid), 64'd0);
      chk("rd_idle_gid", 64'(bus.gnt_id),    64'd0);
      step();

      // contention: ptr=0, so grants go 1,0,1,0
      bus.req_ren[0]   = 1'b1;
      bus.req_wen[1]   = 1'b1;
      bus.req_addr[1]  = 32'h20;
      bus.req_store[1] = 32'h99;
      bus.ramstate     = ACCESS;
      for (int i = 1; i <= 8; i++) begin
         step(); #1;
         if (i % 2 == 1) begin
            chk("rr_gnt_valid", 64'(bus.gnt_valid), 64'd1);
            chk("rr_gnt_id",    64'(bus.gnt_id),    64'(exp_seq[(i - 1) / 2]));
         end else begin
            chk("rr_idle", 64'(bus.gnt_valid), 64'd0);
         end
      end

      // locked two-word write by requester 1 while requester 0 waits
      wlog.delete();
      bus.req_wen[1]   = 1'b1;
      bus.req_lock[1]  = 1'b1;
      bus.req_addr[1]  = 32'h80;
      bus.req_store[1] = 32'h11;
      bus.req_ren[0]   = 1'b1;
      bus.req_addr[0]  = 32'h10;
      step(); #1;
      chk("bw_wen0",  64'(bus.ramWEN),   64'd1);
      chk("bw_addr0", 64'(bus.ramaddr),  64'h80);
      chk("bw_data0", 64'(bus.ramstore), 64'h11);
      chk("bw_gid",   64'(bus.gnt_id),   64'd1);
      step();
      bus.req_addr[1]  = 32'h84;
      bus.req_store[1] = 32'h22;
      #1;
      chk("bw_gap_wen", 64'(bus.ramWEN),    64'd0);
      chk("bw_gap_gv",  64'(bus.gnt_valid), 64'd1);
      step(); #1;
      chk("bw_addr1", 64'(bus.ramaddr),  64'h84);
      chk("bw_data1", 64'(bus.ramstore), 64'h22);
      step();
      bus.req_wen[1]  = 1'b0;
      bus.req_lock[1] = 1'b0;
      #1;
      chk("bw_end_gv", 64'(bus.gnt_valid), 64'd0);
      step(); #1;
      chk("bw_next_gid", 64'(bus.gnt_id), 64'd0);
      chk("bw_next_ren", 64'(bus.ramREN), 64'd1);
      step();
      bus.req_ren[0] = 1'b0;
      chk("bw_log_n", 64'(wlog.size()), 64'd2);
      if (wlog.size() == 2) begin
         chk("bw_log0", wlog[0], 64'h00000080_00000011);
         chk("bw_log1", wlog[1], 64'h00000084_00000022);
      end

      // burst cap: requester 0 holds lock, requester 1 waits
      bus.req_ren[0]  = 1'b1;
      bus.req_lock[0] = 1'b1;
      step();
      bus.req_ren[1] = 1'b1;
      #1;
      chk("cap_g1", 64'(bus.gnt_id), 64'd0);
      step(); #1;
      chk("cap_gap_ren", 64'(bus.ramREN), 64'd0);
      step(); #1;
      chk("cap_g2", 64'(bus.gnt_id), 64'd0);
      chk("cap_ren2", 64'(bus.ramREN), 64'd1);
      step(); #1;
      chk("cap_idle", 64'(bus.gnt_valid), 64'd0);
      step(); #1;
      chk("cap_g3", 64'(bus.gnt_id), 64'd1);
      step();
      bus.req_ren  = '0;
      bus.req_lock = '0;

      // ERROR during grant to requester 1
      bus.req_ren[1] = 1'b1;
      bus.ramstate   = BUSY;
      step();
      bus.ramstate = ERROR;
      #1;
      chk("err_pulse", 64'(bus.req_err[1]),  64'd1);
      chk("err_wait",  64'(bus.req_wait[1]), 64'd0);
      step();
      bus.ramstate   = BUSY;
      bus.req_ren[1] = 1'b0;
      #1;
      chk("err_gone", 64'(bus.req_err),   64'd0);
      chk("err_idle", 64'(bus.gnt_valid), 64'd0);

      // abort: requester 0 drops ren while RAM is BUSY
      bus.req_ren[0] = 1'b1;
      step();
      bus.req_ren[0] = 1'b0;
      #1;
      chk("ab_gv", 64'(bus.gnt_valid), 64'd1);
      step(); #1;
      chk("ab_idle", 64'(bus.gnt_valid), 64'd0);
      chk("ab_err",  64'(bus.req_err),   64'd0);

      // ren+wen together, then reset mid-grant
      bus.req_ren[0]  = 1'b1;
      bus.req_wen[0]  = 1'b1;
      bus.req_addr[0] = 32'h55;
      step(); #1;
      chk("rw_wen", 64'(bus.ramWEN), 64'd1);
      chk("rw_ren", 64'(bus.ramREN), 64'd0);
      nRST = 1'b0;
      step(); #1;
      chk("rr_rst_gv",   64'(bus.gnt_valid), 64'd0);
      chk("rr_rst_wen",  64'(bus.ramWEN),    64'd0);
      chk("rr_rst_wait", 64'(bus.req_wait),  64'h3);
      chk("rr_rst_addr", 64'(bus.ramaddr),   64'd0);
      nRST           = 1'b1;
      bus.req_ren[1] = 1'b1;
      bus.ramstate   = ACCESS;
      step(); #1;
      chk("rr_rst_first", 64'(bus.gnt_id),    64'd0);
      chk("rr_rst_gv2",   64'(bus.gnt_valid), 64'd1);
      step();
      bus.req_ren  = '0;
      bus.req_wen  = '0;
      bus.ramstate = FREE;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
